// File: rtl/i_decode_stage_pkg.sv
// i_decode_stage_pkg: shared definitions for the MIPS Instruction Decode stage.
//   - opcode / funct codes recognised by the decoder
//   - ALUOp encodings and control-bundle widths
//   - ctrl_t control bundle and decode_ctrl() helper
package i_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  // Unknown opcodes and unsupported R-type functs fall through to all-zero (NOP).
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        if (instr[5:0] == FN_ADD || instr[5:0] == FN_SUB || instr[5:0] == FN_AND ||
            instr[5:0] == FN_OR  || instr[5:0] == FN_SLT) begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
          c.alu_op    = ALUOP_RTYPE;
        end
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALUOP_ADD;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_BEQ;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i_decode_stage_if.sv
// i_decode_stage_if: bus between I_FETCH / WB / EX-MEM and the decode stage.
//   Inputs to decode : IF_ID_INSTR, IF_ID_NPC, WB_REG_WRITE, WB_WRITE_REG,
//                      WB_WRITE_DATA, FLUSH
//   Outputs of decode: PC_WRITE, IFIDWrite, ID_EX_* pipeline register
//   slave  = the decode stage, master = whatever drives its inputs.
interface i_decode_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       IF_ID_INSTR;
  logic [DATA_W-1:0] IF_ID_NPC;
  logic              WB_REG_WRITE;
  logic [4:0]        WB_WRITE_REG;
  logic [DATA_W-1:0] WB_WRITE_DATA;
  logic              FLUSH;

  logic              PC_WRITE;
  logic              IFIDWrite;
  logic [1:0]        ID_EX_WB;
  logic [2:0]        ID_EX_M;
  logic [3:0]        ID_EX_EX;
  logic [DATA_W-1:0] ID_EX_NPC;
  logic [DATA_W-1:0] ID_EX_RD1;
  logic [DATA_W-1:0] ID_EX_RD2;
  logic [DATA_W-1:0] ID_EX_IMM;
  logic [4:0]        ID_EX_RS;
  logic [4:0]        ID_EX_RT;
  logic [4:0]        ID_EX_RD;

  modport slave (
    input  IF_ID_INSTR, IF_ID_NPC, WB_REG_WRITE, WB_WRITE_REG, WB_WRITE_DATA, FLUSH,
    output PC_WRITE, IFIDWrite, ID_EX_WB, ID_EX_M, ID_EX_EX, ID_EX_NPC,
           ID_EX_RD1, ID_EX_RD2, ID_EX_IMM, ID_EX_RS, ID_EX_RT, ID_EX_RD
  );

  modport master (
    output IF_ID_INSTR, IF_ID_NPC, WB_REG_WRITE, WB_WRITE_REG, WB_WRITE_DATA, FLUSH,
    input  PC_WRITE, IFIDWrite, ID_EX_WB, ID_EX_M, ID_EX_EX, ID_EX_NPC,
           ID_EX_RD1, ID_EX_RD2, ID_EX_IMM, ID_EX_RS, ID_EX_RT, ID_EX_RD
  );

endinterface

// File: rtl/i_decode_stage_reg_file.sv
// i_decode_stage_reg_file: NREG x DATA_W register file.
//   CLK, RST       : clock, async active-low reset (clears all entries)
//   ra1_i/ra2_i    : async read addresses -> rd1_o/rd2_o
//   we_i/wa_i/wd_i : synchronous write port
//   Entry 0 reads as zero and ignores writes. A write to the address being
//   read is forwarded to the read port in the same cycle.
module i_decode_stage_reg_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AW-1:0]     ra1_i,
  input  logic [AW-1:0]     ra2_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && wa_i != '0 && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i != '0 && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/i_decode_stage.sv
// i_decode_stage: Instruction Decode stage of the 5-stage MIPS pipeline.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-low reset
//   bus  : i_decode_stage_if.slave -- IF/ID inputs, WB write port, FLUSH,
//          stall outputs (PC_WRITE/IFIDWrite) and the ID/EX register.
//   Reads the register file, decodes control, detects load-use hazards and
//   registers everything into ID/EX with one cycle of latency.
module i_decode_stage
  import i_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic            CLK,
  input  logic            RST,
  i_decode_stage_if.slave bus
);

  logic [31:0]       instr;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              hazard;
  ctrl_t             ctrl_dec;

  ctrl_t             ctrl_d, ctrl_q;
  logic [DATA_W-1:0] npc_d, npc_q;
  logic [DATA_W-1:0] rd1_d, rd1_q;
  logic [DATA_W-1:0] rd2_d, rd2_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [4:0]        rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;

  assign instr = bus.IF_ID_INSTR;
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  i_decode_stage_reg_file #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_reg_file (
    .CLK   (CLK),
    .RST   (RST),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (bus.WB_REG_WRITE),
    .wa_i  (bus.WB_WRITE_REG),
    .wd_i  (bus.WB_WRITE_DATA),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  // Load in EX whose destination feeds this instruction: hold IF and IF/ID
  // for one cycle. The bubble clears mem_read, so the stall self-releases.
  assign hazard = ctrl_q.mem_read && rt_q != 5'd0 && (rt_q == rs || rt_q == rt);

  assign bus.PC_WRITE  = ~hazard;
  assign bus.IFIDWrite = ~hazard;

  assign ctrl_dec = decode_ctrl(instr);

  always_comb begin
    ctrl_d = (hazard || bus.FLUSH) ? ctrl_t'('0) : ctrl_dec;
    npc_d  = bus.IF_ID_NPC;
    rd1_d  = rf_rd1;
    rd2_d  = rf_rd2;
    imm_d  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    rs_d   = rs;
    rt_d   = rt;
    rd_d   = rd;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctrl_q <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      npc_q  <= npc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.ID_EX_WB  = {ctrl_q.reg_write, ctrl_q.mem_to_reg};
  assign bus.ID_EX_M   = {ctrl_q.branch, ctrl_q.mem_read, ctrl_q.mem_write};
  assign bus.ID_EX_EX  = {ctrl_q.reg_dst, ctrl_q.alu_op, ctrl_q.alu_src};
  assign bus.ID_EX_NPC = npc_q;
  assign bus.ID_EX_RD1 = rd1_q;
  assign bus.ID_EX_RD2 = rd2_q;
  assign bus.ID_EX_IMM = imm_q;
  assign bus.ID_EX_RS  = rs_q;
  assign bus.ID_EX_RT  = rt_q;
  assign bus.ID_EX_RD  = rd_q;

endmodule

// File: tb/tb_i_decode_stage.sv
module tb_i_decode_stage;

  typedef struct {
    logic [8:0]  ctrl;   // {WB[1:0], M[2:0], EX[3:0]}
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  i_decode_stage_if bus ();

  i_decode_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb_q[$];
  logic [31:0] mregs [32];
  logic [2:0]  m_prev;
  logic [4:0]  rt_prev;
  logic        st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [8:0] ref_ctrl(input logic [31:0] instr);
    logic [5:0] op, fn;
    op = instr[31:26];
    fn = instr[5:0];
    case (op)
      6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                      ? 9'b10_000_1100 : 9'b0;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      6'h08:   return 9'b10_000_0001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_prev  = 3'd0;
    rt_prev = 5'd0;
    sb_q.delete();
  endtask

  // One decode cycle: drive at negedge, check stall outputs, push expectation,
  // then pop and compare the ID/EX register after the rising edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] npc, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                      output logic stalled);
    exp_t e, o;
    logic haz;
    @(negedge CLK);
    bus.IF_ID_INSTR   = instr;
    bus.IF_ID_NPC     = npc;
    bus.WB_REG_WRITE  = we;
    bus.WB_WRITE_REG  = wa;
    bus.WB_WRITE_DATA = wd;
    bus.FLUSH         = fl;
    #1;
    haz = m_prev[1] && rt_prev != 5'd0 && (rt_prev == instr[25:21] || rt_prev == instr[20:16]);
    chk("pc_write",  {31'd0, bus.PC_WRITE},  {31'd0, !haz});
    chk("ifidwrite", {31'd0, bus.IFIDWrite}, {31'd0, !haz});
    e.ctrl = (haz || fl) ? 9'd0 : ref_ctrl(instr);
    e.npc  = npc;
    e.rd1  = ref_read(instr[25:21], we, wa, wd);
    e.rd2  = ref_read(instr[20:16], we, wa, wd);
    e.imm  = {{16{instr[15]}}, instr[15:0]};
    e.rs   = instr[25:21];
    e.rt   = instr[20:16];
    e.rd   = instr[15:11];
    sb_q.push_back(e);
    m_prev  = e.ctrl[6:4];
    rt_prev = instr[20:16];
    if (we && wa != 5'd0) mregs[wa] = wd;
    stalled = haz;
    @(posedge CLK);
    #1;
    o = sb_q.pop_front();
    chk("id_ex_ctrl", {23'd0, bus.ID_EX_WB, bus.ID_EX_M, bus.ID_EX_EX}, {23'd0, o.ctrl});
    chk("id_ex_npc",  bus.ID_EX_NPC, o.npc);
    chk("id_ex_rd1",  bus.ID_EX_RD1, o.rd1);
    chk("id_ex_rd2",  bus.ID_EX_RD2, o.rd2);
    chk("id_ex_imm",  bus.ID_EX_IMM, o.imm);
    chk("id_ex_regs", {17'd0, bus.ID_EX_RS, bus.ID_EX_RT, bus.ID_EX_RD}, {17'd0, o.rs, o.rt, o.rd});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb"},  {30'd0, bus.ID_EX_WB}, 32'd0);
    chk({tag, "_m"},   {29'd0, bus.ID_EX_M},  32'd0);
    chk({tag, "_ex"},  {28'd0, bus.ID_EX_EX}, 32'd0);
    chk({tag, "_npc"}, bus.ID_EX_NPC, 32'd0);
    chk({tag, "_rd1"}, bus.ID_EX_RD1, 32'd0);
    chk({tag, "_rd2"}, bus.ID_EX_RD2, 32'd0);
    chk({tag, "_imm"}, bus.ID_EX_IMM, 32'd0);
    chk({tag, "_rsrtrd"}, {17'd0, bus.ID_EX_RS, bus.ID_EX_RT, bus.ID_EX_RD}, 32'd0);
  endtask

  initial begin
    bus.IF_ID_INSTR   = 32'd0;
    bus.IF_ID_NPC     = 32'd0;
    bus.WB_REG_WRITE  = 1'b0;
    bus.WB_WRITE_REG  = 5'd0;
    bus.WB_WRITE_DATA = 32'd0;
    bus.FLUSH         = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("reset_pc_write", {31'd0, bus.PC_WRITE}, 32'd1);

    // WB $5, then add $3,$5,$0
    step(32'd0, 32'h0000_0004, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, st);
    step(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h0000_0008, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t2_rd1", bus.ID_EX_RD1, 32'hDEAD_BEEF);
    chk("t2_ex",  {28'd0, bus.ID_EX_EX}, 32'hC);
    chk("t2_wb",  {30'd0, bus.ID_EX_WB}, 32'h2);

    // same-cycle bypass into addi $8,$7,-4
    step(itype(6'h08, 5'd7, 5'd8, 16'hFFFC), 32'h0000_000C, 1'b1, 5'd7, 32'h1234_5678, 1'b0, st);
    chk("t3_rd1", bus.ID_EX_RD1, 32'h1234_5678);
    chk("t3_imm", bus.ID_EX_IMM, 32'hFFFF_FFFC);

    // write to $0 ignored, rt bypass, other R-type functs, sw, bad funct
    step(32'd0, 32'h10, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, st);
    step(rtype(5'd0, 5'd7, 5'd9, 6'h2A), 32'h14, 1'b1, 5'd7, 32'hA5A5_0001, 1'b0, st);
    chk("zero_reg_read", bus.ID_EX_RD1, 32'd0);
    step(rtype(5'd7, 5'd5, 5'd10, 6'h22), 32'h18, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(itype(6'h2B, 5'd5, 5'd7, 16'h0010), 32'h1C, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, st);

    // load-use: lw $2,0($1); add $4,$2,$3 stalls once, then issues
    step(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h24, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h28, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t4_bubble_wb", {30'd0, bus.ID_EX_WB}, 32'd0);
    chk("t4_bubble_m",  {29'd0, bus.ID_EX_M},  32'd0);
    step(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h28, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t4_issue_wb", {30'd0, bus.ID_EX_WB}, 32'h2);

    // lw to $0 never stalls
    step(itype(6'h23, 5'd1, 5'd0, 16'h0000), 32'h2C, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(rtype(5'd0, 5'd3, 5'd4, 6'h20), 32'h30, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t5_no_stall_wb", {30'd0, bus.ID_EX_WB}, 32'h2);

    // load-use on rt, with FLUSH in the same cycle
    step(itype(6'h23, 5'd1, 5'd6, 16'h0004), 32'h34, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(rtype(5'd3, 5'd6, 5'd4, 6'h25), 32'h38, 1'b0, 5'd0, 32'd0, 1'b1, st);
    step(rtype(5'd3, 5'd6, 5'd4, 6'h25), 32'h38, 1'b0, 5'd0, 32'd0, 1'b0, st);

    // FLUSH over beq, then NOP encodings
    step(itype(6'h04, 5'd1, 5'd2, 16'h8000), 32'h3C, 1'b0, 5'd0, 32'd0, 1'b1, st);
    chk("t6_flush_m",  {29'd0, bus.ID_EX_M},  32'd0);
    chk("t6_flush_wb", {30'd0, bus.ID_EX_WB}, 32'd0);
    step(itype(6'h04, 5'd1, 5'd2, 16'h8000), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t6_beq_m", {29'd0, bus.ID_EX_M}, 32'h4);
    step(32'h0000_0000, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(32'hFC00_1234, 32'h48, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("t6_op3f_ctrl", {23'd0, bus.ID_EX_WB, bus.ID_EX_M, bus.ID_EX_EX}, 32'd0);

    // mid-run async reset while ID/EX holds a lw
    step(itype(6'h23, 5'd5, 5'd9, 16'h7FF0), 32'h4C, 1'b0, 5'd0, 32'd0, 1'b0, st);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    chk("midrun_reset_pc_write", {31'd0, bus.PC_WRITE}, 32'd1);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    // register file must have been cleared too
    step(rtype(5'd5, 5'd7, 5'd1, 6'h24), 32'h50, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("rf_cleared", bus.ID_EX_RD1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
